// File: rtl/nv_nvdla_cmac_seq.sv
// CMAC layer sequencer: tracks in-flight packets, detects layer completion, drives clock-gate enables.
// Optional stall watchdog enabled by defining NVDLA_CMAC_SEQ_WATCHDOG_EN.
module nv_nvdla_cmac_seq #(
    parameter int CMAC_SLCG_NUM = 3,
    parameter int INFL_W        = 4,
    parameter int SLCG_HOLD     = 4,
    parameter int WDOG_CYC      = 1024
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    input  logic                     reg2dp_op_en,
    input  logic                     reg2dp_conv_mode,
    input  logic                     sc2mac_dat_pvld,
    input  logic [8:0]               sc2mac_dat_pd,
    input  logic                     mac2accu_pvld,
    input  logic [8:0]               mac2accu_pd,
    output logic                     dp2reg_done,
    output logic [CMAC_SLCG_NUM-1:0] slcg_op_en,
    output logic                     cmac_mode,
    output logic                     seq_busy,
    output logic                     seq_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} seq_state_t;

    localparam int HOLD_W = (SLCG_HOLD < 1) ? 1 : $clog2(SLCG_HOLD + 1);
    localparam logic [INFL_W-1:0] INFL_MAX = '1;

    seq_state_t        state_reg, state_next;
    logic [INFL_W-1:0] infl_cnt_reg, cnt_upd;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              in_end_reg, out_end_reg, armed_reg, slcg_reg;
    logic              in_last, out_last, out_end_seen, busy_state;
    logic              sat_hi, sat_lo, in_err, err_hit;
    logic              layer_start, layer_abort, flush, wdog_fire;
    logic              unused_pd_bits;

    assign unused_pd_bits = ^{sc2mac_dat_pd[7:0], mac2accu_pd[7:0]};

    assign in_last      = sc2mac_dat_pvld & sc2mac_dat_pd[8];
    assign out_last     = mac2accu_pvld & mac2accu_pd[8];
    assign out_end_seen = out_end_reg | out_last;
    assign busy_state   = (state_reg == S_RUN) || (state_reg == S_DRAIN);

    // Simultaneous in/out cancel; lone updates saturate at the counter limits.
    assign sat_hi = sc2mac_dat_pvld & ~mac2accu_pvld & (infl_cnt_reg == INFL_MAX);
    assign sat_lo = ~sc2mac_dat_pvld & mac2accu_pvld & (infl_cnt_reg == '0);

    always_comb begin
        cnt_upd = infl_cnt_reg;
        if (sc2mac_dat_pvld && !mac2accu_pvld && !sat_hi)
            cnt_upd = infl_cnt_reg + INFL_W'(1);
        else if (!sc2mac_dat_pvld && mac2accu_pvld && !sat_lo)
            cnt_upd = infl_cnt_reg - INFL_W'(1);
    end

    assign in_err = sc2mac_dat_pvld &
                    ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                     ((state_reg == S_DRAIN) && in_end_reg));
    assign err_hit = sat_hi | sat_lo | in_err | wdog_fire;

`ifdef NVDLA_CMAC_SEQ_WATCHDOG_EN
    localparam int WDOG_W = (WDOG_CYC < 2) ? 1 : $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0] wdog_cnt_reg;

    // Fires on the WDOG_CYC-th consecutive cycle without any packet activity.
    assign wdog_fire = busy_state & reg2dp_op_en & ~sc2mac_dat_pvld & ~mac2accu_pvld &
                       (wdog_cnt_reg == WDOG_W'(WDOG_CYC - 1));

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn)
            wdog_cnt_reg <= '0;
        else if (!busy_state || sc2mac_dat_pvld || mac2accu_pvld || wdog_fire)
            wdog_cnt_reg <= '0;
        else
            wdog_cnt_reg <= wdog_cnt_reg + WDOG_W'(1);
    end
`else
    localparam int WDOG_LIMIT_UNUSED = WDOG_CYC;
    assign wdog_fire = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        layer_start = 1'b0;
        layer_abort = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (reg2dp_op_en && armed_reg) begin
                    state_next  = S_RUN;
                    layer_start = 1'b1;
                end
            end
            S_RUN: begin
                if (!reg2dp_op_en) begin
                    state_next  = S_IDLE;
                    layer_abort = 1'b1;
                end else if (in_last)
                    state_next = S_DRAIN;
                else if (wdog_fire)
                    state_next = S_DONE;
            end
            S_DRAIN: begin
                if (!reg2dp_op_en) begin
                    state_next  = S_IDLE;
                    layer_abort = 1'b1;
                end else if (out_end_seen && (cnt_upd == '0))
                    state_next = S_DONE;
                else if (wdog_fire)
                    state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign flush = layer_abort | wdog_fire;

    // Clock gates stay open for SLCG_HOLD cycles after the layer leaves the active states.
    always_comb begin
        hold_next = hold_reg;
        if (state_reg != S_IDLE && state_next == S_IDLE)
            hold_next = HOLD_W'(SLCG_HOLD);
        else if (state_next != S_IDLE)
            hold_next = '0;
        else if (hold_reg != '0)
            hold_next = hold_reg - HOLD_W'(1);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_reg    <= S_IDLE;
            infl_cnt_reg <= '0;
            in_end_reg   <= 1'b0;
            out_end_reg  <= 1'b0;
            armed_reg    <= 1'b1;
            hold_reg     <= '0;
            slcg_reg     <= 1'b0;
            dp2reg_done  <= 1'b0;
            cmac_mode    <= 1'b0;
            seq_busy     <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            infl_cnt_reg <= flush ? '0 : cnt_upd;
            hold_reg     <= hold_next;

            if (flush || state_reg == S_DONE)
                in_end_reg <= 1'b0;
            else if (state_reg == S_RUN && in_last)
                in_end_reg <= 1'b1;

            if (flush || state_reg == S_DONE)
                out_end_reg <= 1'b0;
            else if (busy_state && out_last)
                out_end_reg <= 1'b1;

            // A finished layer must see op_en low before the next one may start.
            if (state_next == S_DONE)
                armed_reg <= 1'b0;
            else if (!reg2dp_op_en)
                armed_reg <= 1'b1;

            if (layer_start)
                cmac_mode <= reg2dp_conv_mode;

            if (layer_start)
                seq_err <= 1'b0;
            else if (err_hit)
                seq_err <= 1'b1;

            dp2reg_done <= (state_next == S_DONE);
            seq_busy    <= (state_next == S_RUN) || (state_next == S_DRAIN);
            slcg_reg    <= (state_next != S_IDLE) || (hold_next != '0);
        end
    end

    assign slcg_op_en = {CMAC_SLCG_NUM{slcg_reg}};

endmodule

// File: tb/tb_nv_nvdla_cmac_seq.sv
// Self-checking bench for nv_nvdla_cmac_seq: directed layer scenarios plus randomized layers,
// all outputs compared every cycle against a behavioural model of the layer sequencing rules.
module tb_nv_nvdla_cmac_seq;

    localparam int SLCG_N   = 3;
    localparam int INFL_W   = 4;
    localparam int HOLD     = 4;
    localparam int WDOG     = 16;
    localparam int INFL_MAX = (1 << INFL_W) - 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              op_en = 1'b0;
    logic              conv_mode = 1'b0;
    logic              in_v = 1'b0;
    logic [8:0]        in_pd = '0;
    logic              out_v = 1'b0;
    logic [8:0]        out_pd = '0;
    logic              done;
    logic [SLCG_N-1:0] slcg;
    logic              mode, busy, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nv_nvdla_cmac_seq #(
        .CMAC_SLCG_NUM(SLCG_N),
        .INFL_W       (INFL_W),
        .SLCG_HOLD    (HOLD),
        .WDOG_CYC     (WDOG)
    ) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .reg2dp_op_en    (op_en),
        .reg2dp_conv_mode(conv_mode),
        .sc2mac_dat_pvld (in_v),
        .sc2mac_dat_pd   (in_pd),
        .mac2accu_pvld   (out_v),
        .mac2accu_pd     (out_pd),
        .dp2reg_done     (done),
        .slcg_op_en      (slcg),
        .cmac_mode       (mode),
        .seq_busy        (busy),
        .seq_err         (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_on, m_done, m_inclosed, m_outclosed, m_armed, m_err, m_mode;
    int m_infl, m_hold, m_idle;

    function automatic void m_reset();
        m_on = 0; m_done = 0; m_inclosed = 0; m_outclosed = 0;
        m_armed = 1; m_err = 0; m_mode = 0;
        m_infl = 0; m_hold = 0; m_idle = 0;
    endfunction

    function automatic void m_step();
        int d;
        bit es, start, wd, draining;
        es = 0; start = 0; wd = 0;
        d = m_infl + int'(in_v) - int'(out_v);
        if (d > INFL_MAX) begin d = INFL_MAX; es = 1; end
        if (d < 0) begin d = 0; es = 1; end
        if (in_v && (!m_on || m_inclosed)) es = 1;
        if (m_done) begin
            m_done = 0; m_hold = HOLD; m_inclosed = 0; m_outclosed = 0;
            if (!op_en) m_armed = 1;
        end else if (!m_on) begin
            if (op_en && m_armed) begin
                start = 1; m_on = 1; m_mode = conv_mode; m_hold = 0; m_idle = 0;
            end else begin
                if (m_hold > 0) m_hold--;
                if (!op_en) m_armed = 1;
            end
        end else if (!op_en) begin
            m_on = 0; d = 0; m_inclosed = 0; m_outclosed = 0;
            m_hold = HOLD; m_armed = 1; m_idle = 0;
        end else begin
            draining = m_inclosed;
            if (in_v && in_pd[8]) m_inclosed = 1;
            if (out_v && out_pd[8]) m_outclosed = 1;
            if (in_v || out_v) m_idle = 0; else m_idle++;
`ifdef NVDLA_CMAC_SEQ_WATCHDOG_EN
            wd = (m_idle >= WDOG);
`endif
            if (wd) begin es = 1; m_idle = 0; end
            if (draining && m_outclosed && d == 0) begin
                m_on = 0; m_done = 1; m_armed = 0;
            end else if (wd) begin
                m_on = 0; m_done = 1; m_armed = 0; d = 0;
                m_inclosed = 0; m_outclosed = 0;
            end
        end
        m_infl = d;
        m_err = start ? 1'b0 : (m_err | es);
    endfunction

    // Compare every cycle on the falling edge, then advance the model with the inputs
    // that the next rising edge will sample.
    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (!rstn) m_reset();
            chk("model_done", done, m_done);
            chk("model_busy", busy, m_on);
            chk("model_slcg", slcg, (m_on || m_done || m_hold > 0) ? {SLCG_N{1'b1}} : '0);
            chk("model_mode", mode, m_mode);
            chk("model_err",  err,  m_err);
            if (rstn) m_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_v = 0; out_v = 0; in_pd = '0; out_pd = '0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone, cyc, n_in, sent, got, abort_at;
        #1 rstn = 0;
        repeat (3) tick();
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_slcg", slcg, 0);
        chk("rst_err",  err,  0);
        chk("rst_mode", mode, 0);
        rstn = 1;
        tick();

        // Basic layer: 5 inputs, outputs trail by 3 cycles
        op_en = 1; conv_mode = 1;
        tick();
        conv_mode = 0;
        chk("t1_busy_start", busy, 1);
        chk("t1_mode", mode, 1);
        chk("t1_slcg_on", slcg, 3'b111);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            in_v   = (c < 5);
            in_pd  = {(c == 4), 8'(c)};
            out_v  = (c >= 3);
            out_pd = {(c == 7), 8'(c)};
            tick();
            if (c < 7) ndone += int'(done);
        end
        idle();
        chk("t1_early_done", ndone, 0);
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        tick();
        chk("t1_done_single", done, 0);
        repeat (3) tick();
        chk("t1_slcg_hold", slcg, 3'b111);
        tick();
        chk("t1_slcg_off", slcg, 0);
        chk("t1_no_restart", busy, 0);

        // Abort mid-RUN with three packets in flight
        op_en = 0; tick(); op_en = 1; tick();
        chk("t2_busy", busy, 1);
        repeat (3) begin in_v = 1; tick(); end
        idle();
        op_en = 0;
        tick();
        chk("t2_abort_busy", busy, 0);
        chk("t2_abort_done", done, 0);
        repeat (3) tick();
        chk("t2_slcg_hold", slcg, 3'b111);
        tick();
        chk("t2_slcg_off", slcg, 0);

        // Output with empty counter flags an error; a new layer clears it
        out_v = 1; tick(); idle();
        chk("t3_err_set", err, 1);
        tick();
        chk("t3_err_sticky", err, 1);
        op_en = 1; tick();
        chk("t3_err_clear", err, 0);

        // Output layer_end with two packets still in flight
        for (int c = 0; c < 3; c++) begin in_v = 1; in_pd = {(c == 2), 8'h0}; tick(); end
        idle();
        out_v = 1; out_pd = 9'h100; tick(); idle();
        chk("t4_hold_drain", busy, 1);
        chk("t4_no_done", done, 0);
        out_v = 1; tick();
        chk("t4_no_done2", done, 0);
        tick(); idle();
        chk("t4_done", done, 1);

        // Simultaneous in/out keep the counter constant
        op_en = 0; tick(); op_en = 1; tick();
        in_v = 1; tick();
        for (int k = 0; k < 6; k++) begin
            in_v = 1; in_pd = {(k == 5), 8'h0}; out_v = 1; out_pd = '0;
            tick();
            chk("t5_no_done", done, 0);
        end
        idle(); tick();
        chk("t5_still_busy", busy, 1);
        out_v = 1; out_pd = 9'h100; tick(); idle();
        chk("t5_done", done, 1);

        // Counter saturation at all-ones
        op_en = 0; tick();
        repeat (16) begin in_v = 1; tick(); end
        idle();
        chk("t6_idle_err", err, 1);
        op_en = 1; tick();
        chk("t6_err_clear", err, 0);
        in_v = 1; in_pd = 9'h100; tick(); idle();
        chk("t6_sat_err", err, 1);
        for (int k = 0; k < INFL_MAX; k++) begin
            out_v = 1; out_pd = {(k == INFL_MAX - 1), 8'h0}; tick();
        end
        idle();
        chk("t6_done", done, 1);

        // Asynchronous reset mid-layer
        op_en = 0; tick(); op_en = 1; tick();
        in_v = 1; tick(); tick(); idle();
        @(posedge clk);
        #3 rstn = 0;
        #1;
        chk("t7_async_busy", busy, 0);
        chk("t7_async_slcg", slcg, 0);
        op_en = 0;
        repeat (2) tick();
        rstn = 1;
        ndone = 0;
        repeat (6) begin tick(); ndone += int'(done); end
        chk("t7_no_done", ndone, 0);

        // Stall after input end with no outputs
        op_en = 1; tick();
        in_v = 1; tick(); in_pd = 9'h100; tick(); idle();
`ifdef NVDLA_CMAC_SEQ_WATCHDOG_EN
        cyc = 0;
        while (!done && cyc < 40) begin tick(); cyc++; end
        chk("t8_wdog_latency", cyc, WDOG);
        chk("t8_wdog_err", err, 1);
        op_en = 0; tick();
`else
        repeat (40) tick();
        chk("t8_wait_no_done", done, 0);
        chk("t8_wait_busy", busy, 1);
        op_en = 0; tick();
        chk("t8_abort", busy, 0);
`endif

        // Randomized layers
        for (int L = 0; L < 40; L++) begin
            idle(); op_en = 0;
            repeat ($urandom_range(1, 2)) tick();
            if ($urandom_range(0, 7) == 0) begin out_v = 1; tick(); idle(); end
            op_en = 1; conv_mode = 1'($urandom_range(0, 1));
            tick();
            conv_mode = 1'($urandom_range(0, 1));
            n_in = $urandom_range(1, 10);
            sent = 0; got = 0;
            abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 20) : -1;
            for (int c = 0; c < 300 && got < n_in; c++) begin
                if (c == abort_at) begin idle(); op_en = 0; break; end
                in_v   = (sent < n_in) && ($urandom_range(0, 2) != 0);
                out_v  = ((sent - got) > 0) && ($urandom_range(0, 1) == 1);
                in_pd  = {(in_v && sent == n_in - 1), 8'($urandom)};
                out_pd = {(out_v && got == n_in - 1), 8'($urandom)};
                tick();
                sent += int'(in_v);
                got  += int'(out_v);
            end
            idle();
            repeat (3) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_cmac_seq.md
NV_NVDLA_CMAC_SEQ -- requirements
Module: nv_nvdla_cmac_seq

Interface
REQ-001 SHALL have parameter CMAC_SLCG_NUM, default 3: width of slcg_op_en.
REQ-002 SHALL have parameter INFL_W, default 4: in-flight counter width, max 2^INFL_W-1 packets.
REQ-003 SHALL have parameter SLCG_HOLD, default 4: cycles slcg_op_en stays high after done.
REQ-004 SHALL have parameter WDOG_CYC, default 1024: watchdog stall limit in cycles.
REQ-005 nvdla_core_clk  in  1  sole clock; all flops on rising edge.
REQ-006 nvdla_core_rstn  in  1  reset, asynchronous, active-low.
REQ-007 reg2dp_op_en  in  1  layer enable level from CMAC register file.
REQ-008 reg2dp_conv_mode  in  1  0=direct, 1=winograd; sampled at layer start.
REQ-009 sc2mac_dat_pvld  in  1  input packet valid.
REQ-010 sc2mac_dat_pd  in  9  input packet info; bit 8 = layer_end.
REQ-011 mac2accu_pvld  in  1  output packet valid from MAC core.
REQ-012 mac2accu_pd  in  9  output packet info; bit 8 = layer_end.
REQ-013 dp2reg_done  out  1  one-cycle layer-complete pulse.
REQ-014 slcg_op_en  out  CMAC_SLCG_NUM  clock-gate enables, all bits identical.
REQ-015 cmac_mode  out  1  latched conv_mode for the active layer.
REQ-016 seq_busy  out  1  high in RUN or DRAIN.
REQ-017 seq_err  out  1  sticky protocol error flag.

Function
REQ-018 States SHALL be IDLE, RUN, DRAIN, DONE; encoding is free.
REQ-019 IDLE->RUN SHALL occur on the first cycle reg2dp_op_en=1; cmac_mode latches reg2dp_conv_mode on that edge.
REQ-020 In-flight counter SHALL increment on sc2mac_dat_pvld and decrement on mac2accu_pvld; both in the same cycle SHALL leave it unchanged.
REQ-021 sc2mac_dat_pvld with pd[8]=1 in RUN SHALL set an in_end flag and move to DRAIN.
REQ-022 DRAIN->DONE SHALL occur in the cycle after mac2accu_pvld with pd[8]=1 has been seen and the post-update counter is 0, in either order.
REQ-023 DONE SHALL last exactly one cycle with dp2reg_done=1, then go to IDLE; done latency is 1 cycle after the final counter-zero edge.
REQ-024 After DONE, IDLE SHALL NOT re-enter RUN until reg2dp_op_en has been sampled 0 for at least one cycle.
REQ-025 slcg_op_en SHALL be all-ones from the RUN entry edge through SLCG_HOLD cycles after DONE, else zero.
REQ-026 Counter increment at all-ones or decrement at zero SHALL saturate and set seq_err.
REQ-027 sc2mac_dat_pvld in IDLE or DONE, or in DRAIN after in_end, SHALL set seq_err; the counter still updates.
REQ-028 reg2dp_op_en falling to 0 in RUN or DRAIN SHALL abort: go to IDLE next cycle, clear the counter and in_end, and set no done pulse.
REQ-029 seq_err SHALL clear only on reset or on the IDLE->RUN transition.

Reset
REQ-030 Reset SHALL force state IDLE, counter 0, in_end 0, hold counter 0, dp2reg_done 0, slcg_op_en 0, cmac_mode 0, seq_busy 0, seq_err 0.
REQ-031 Reset asserted mid-layer SHALL take effect immediately without a clock edge; no done pulse follows deassertion.

Configuration
REQ-032 Macro NVDLA_CMAC_SEQ_WATCHDOG_EN defined: a counter SHALL run in RUN/DRAIN, reset on any pvld, and on reaching WDOG_CYC set seq_err and force DONE (dp2reg_done pulse).
REQ-033 Macro undefined: no watchdog logic; RUN/DRAIN wait indefinitely.

Verification
REQ-034 op_en=1, 5 input packets (last pd[8]=1), 5 outputs 3 cycles later (last pd[8]=1) -> single dp2reg_done one cycle after last output, seq_err=0.
REQ-035 Same input and output in same cycle repeatedly -> counter constant; done only after output layer_end with counter 0.
REQ-036 Output layer_end arrives while counter=2 -> stay DRAIN; done one cycle after the 2 remaining outputs.
REQ-037 Drop op_en mid-RUN with counter=3 -> IDLE next cycle, counter 0, no done; slcg_op_en 0 after SLCG_HOLD.
REQ-038 mac2accu_pvld with counter=0 -> seq_err=1, counter stays 0; op_en 0 then 1 -> seq_err clears.
REQ-039 With NVDLA_CMAC_SEQ_WATCHDOG_EN, WDOG_CYC=16, no outputs after input end -> done and seq_err at cycle 16.
